// File: rtl/cache_types_pkg.sv
// Shared types and constants for the L1-to-memory arbitration path.
// A cache line is moved as N_BEATS consecutive S_BEAT-wide memory beats.
package cache_types_pkg;

    localparam int S_ADDR  = 32;
    localparam int S_OFF   = 5;
    localparam int S_LINE  = 256;
    localparam int S_BEAT  = 64;
    localparam int N_BEATS = S_LINE / S_BEAT;

    typedef logic [S_LINE-1:0] line_t;
    typedef logic [S_BEAT-1:0] beat_t;
    typedef logic [S_ADDR-1:0] addr_t;

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} arb_state_t;
    typedef enum logic {ICACHE, DCACHE} requester_t;

    // Clears the offset bits by masking, so every address bit stays in use.
    function automatic addr_t line_align(input addr_t addr);
        return addr & ~addr_t'((1 << S_OFF) - 1);
    endfunction

endpackage

// File: rtl/burst_adapter.sv
// Splits a cache line into memory beats and reassembles read beats into a line.
// Counts the accepted beats and flags the last one; done pulses in the cycle after it.
module burst_adapter
    import cache_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  logic  load_wdata,
    input  line_t wdata,
    input  logic  rd_active,
    input  logic  wr_active,
    input  logic  beat_valid,
    input  beat_t rdata,
    output beat_t wbeat,
    output line_t line_next,
    output logic  last_beat,
    output logic  done
);

    logic [1:0] beat_cnt_reg;
    line_t      buffer_reg;
    line_t      wdata_reg;
    logic       done_reg;
    logic       beat_en;
    beat_t      wbeats [N_BEATS];

    assign beat_en   = (rd_active || wr_active) && beat_valid;
    assign last_beat = beat_en && (beat_cnt_reg == 2'(N_BEATS - 1));
    assign done      = done_reg;
    assign wbeat     = wbeats[beat_cnt_reg];

    // line_next is the buffer with the beat currently on the bus already merged in,
    // so the owner can capture the complete line on the edge of the last beat.
    generate
        for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_beat
            assign line_next[gi*S_BEAT +: S_BEAT] =
                (rd_active && beat_valid && (beat_cnt_reg == 2'(gi)))
                    ? rdata : buffer_reg[gi*S_BEAT +: S_BEAT];
            assign wbeats[gi] = wdata_reg[gi*S_BEAT +: S_BEAT];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg <= 2'd0;
            buffer_reg   <= '0;
            wdata_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            if (start) begin
                beat_cnt_reg <= 2'd0;
            end else if (beat_en) begin
                beat_cnt_reg <= beat_cnt_reg + 2'd1;
            end
            if (load_wdata) begin
                wdata_reg <= wdata;
            end
            if (rd_active) begin
                buffer_reg <= line_next;
            end
            done_reg <= last_beat;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one burst memory port between the icache fill path and the dcache read/write-back path.
// Grants alternate between the two caches when they request in the same cycle.
module cache_arbiter
    import cache_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_mem_read,
    input  logic [S_ADDR-1:0]   i_mem_addr,
    output logic [S_LINE-1:0]   i_mem_rdata,
    output logic                i_mem_resp,
    input  logic                d_mem_read,
    input  logic                d_mem_write,
    input  logic [S_ADDR-1:0]   d_mem_addr,
    input  logic [S_LINE-1:0]   d_mem_wdata,
    output logic [S_LINE-1:0]   d_mem_rdata,
    output logic                d_mem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [S_ADDR-1:0]   pmem_addr,
    output logic [S_BEAT-1:0]   pmem_wdata,
    input  logic [S_BEAT-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    arb_state_t state_reg;
    requester_t last_grant_reg;
    logic       pmem_read_reg;
    logic       pmem_write_reg;
    addr_t      pmem_addr_reg;
    line_t      i_rdata_reg;
    line_t      d_rdata_reg;

    logic  d_req;
    logic  grant_d;
    logic  grant_i;
    logic  start;
    logic  load_wdata;
    line_t line_next;
    logic  last_beat;
    logic  done;

    assign d_req      = d_mem_read || d_mem_write;
    assign grant_d    = (state_reg == IDLE) && d_req && (!i_mem_read || last_grant_reg == ICACHE);
    assign grant_i    = (state_reg == IDLE) && i_mem_read && !grant_d;
    assign start      = grant_d || grant_i;
    assign load_wdata = grant_d && d_mem_write;

    assign pmem_read   = pmem_read_reg;
    assign pmem_write  = pmem_write_reg;
    assign pmem_addr   = pmem_addr_reg;
    assign i_mem_rdata = i_rdata_reg;
    assign d_mem_rdata = d_rdata_reg;
    // The most recent grant is always the owner of the burst that just finished.
    assign i_mem_resp  = done && (last_grant_reg == ICACHE);
    assign d_mem_resp  = done && (last_grant_reg == DCACHE);

    burst_adapter u_burst (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_wdata (load_wdata),
        .wdata      (d_mem_wdata),
        .rd_active  (pmem_read_reg),
        .wr_active  (pmem_write_reg),
        .beat_valid (pmem_resp),
        .rdata      (pmem_rdata),
        .wbeat      (pmem_wdata),
        .line_next  (line_next),
        .last_beat  (last_beat),
        .done       (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ICACHE;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            pmem_addr_reg  <= '0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A simultaneous read and write from the dcache is a write-back.
                    if (grant_d) begin
                        state_reg      <= d_mem_write ? D_WR : D_RD;
                        pmem_write_reg <= d_mem_write;
                        pmem_read_reg  <= !d_mem_write;
                        pmem_addr_reg  <= line_align(d_mem_addr);
                        last_grant_reg <= DCACHE;
                    end else if (grant_i) begin
                        state_reg      <= I_RD;
                        pmem_read_reg  <= 1'b1;
                        pmem_addr_reg  <= line_align(i_mem_addr);
                        last_grant_reg <= ICACHE;
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (last_beat) begin
                        state_reg      <= RESP;
                        pmem_read_reg  <= 1'b0;
                        pmem_write_reg <= 1'b0;
                        if (state_reg == I_RD) begin
                            i_rdata_reg <= line_next;
                        end
                        if (state_reg == D_RD) begin
                            d_rdata_reg <= line_next;
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the icache line-fill interface and the dcache line read/write-back interface.
- Converts each 256-bit cache-line transaction into a 4-beat, 64-bit burst on the memory side.
- Sits between both L1 caches and the pmem model/L2.
- Fixed-priority-free: alternates grants when both caches request in the same cycle.

Parameters:
- s_addr, 32, address width
- s_off, 5, line offset bits (32-byte line)
- s_line, 256, cache line width in bits
- s_beat, 64, pmem data width per beat
- n_beats, s_line/s_beat (4), beats per burst

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_mem_read  in  1  icache line-fill request
- i_mem_addr  in  s_addr  icache request address
- i_mem_rdata  out  s_line  fill data to icache
- i_mem_resp  out  1  icache transaction done, 1-cycle pulse
- d_mem_read  in  1  dcache line read request
- d_mem_write  in  1  dcache line write-back request
- d_mem_addr  in  s_addr  dcache request address
- d_mem_wdata  in  s_line  dcache write-back line
- d_mem_rdata  out  s_line  fill data to dcache
- d_mem_resp  out  1  dcache transaction done, 1-cycle pulse
- pmem_read  out  1  burst read active
- pmem_write  out  1  burst write active
- pmem_addr  out  s_addr  line-aligned burst address
- pmem_wdata  out  s_beat  current write beat
- pmem_rdata  in  s_beat  current read beat
- pmem_resp  in  1  beat accepted/valid this cycle

Behaviour:
- Reset: all of the following are 0.
  - Outputs: i_mem_resp, d_mem_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata.
  - State: beat_cnt, line buffer, i_mem_rdata, d_mem_rdata.
  - State = IDLE; last_grant = ICACHE, so the dcache wins the first tie.
- FSM states: IDLE, I_RD, D_RD, D_WR, RESP.
- IDLE: sample requests every cycle.
  - Only i_mem_read pending -> I_RD.
  - Only a dcache request pending -> D_RD or D_WR.
  - Both pending -> grant the requester not equal to last_grant.
  - On grant: latch the address to {addr[31:5],5'b0}; for D_WR also latch d_mem_wdata; clear beat_cnt; update last_grant.
- d_mem_read and d_mem_write both high: treat as a write.
- I_RD / D_RD: pmem_read=1, pmem_addr held constant.
  - Each cycle with pmem_resp=1: buffer[64*beat_cnt +: 64] <= pmem_rdata; beat_cnt++.
  - pmem_resp may stall for any number of cycles between beats.
  - The beat with beat_cnt==3 and pmem_resp=1 -> RESP; pmem_read drops in RESP.
- D_WR: pmem_write=1, pmem_addr held, pmem_wdata = latched_wdata[64*beat_cnt +: 64] (combinational on beat_cnt).
  - Advance on pmem_resp; last beat -> RESP.
- RESP: lasts exactly one cycle; the owner's resp is 1; the other requester's resp stays 0.
  - i_mem_rdata / d_mem_rdata = buffer, registered, stable from the RESP cycle until the next fill for that port.
  - Next state is always IDLE.
- Requester protocol: the requester drops its request at the edge after seeing resp.
  - The IDLE cycle after RESP therefore sees the updated request, with no spurious re-grant.
- Latency, unstalled memory:
  - Grant at edge 0.
  - Beats on cycles 1-4 after grant.
  - resp 1 cycle after the last beat.
  - Next grant earliest 2 cycles after resp.
- Request inputs are ignored outside IDLE; the non-granted requester simply waits with its request held.
- Requester dropping its request mid-burst: the burst completes anyway and resp still pulses.
- rst mid-burst: immediately IDLE, pmem_read/write drop next edge, no resp issued; the memory model must be reset concurrently.
- beat_cnt is 2-bit and wraps 3->0 only on RESP entry; no extra beat is ever counted.

Decomposition:
- Shared package cache_types_pkg holds:
  - Constants S_LINE, S_BEAT, N_BEATS, S_OFF.
  - typedef line_t (logic [255:0]), beat_t (logic [63:0]).
  - enum arb_state_t {IDLE, I_RD, D_RD, D_WR, RESP}.
  - enum requester_t {ICACHE, DCACHE}.
- One natural sub-module, burst_adapter, containing:
  - beat_cnt, the line buffer, the write-data beat mux, and the done pulse.
- cache_arbiter keeps the FSM, the grant logic and address latching.

Test Plan:
- Lone icache read, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. with pmem_resp every cycle:
  - pmem_addr=0x0000_1220.
  - i_mem_rdata = {0x44..,0x33..,0x22..,0x11..}.
  - i_mem_resp pulses 1 cycle; d_mem_resp stays 0.
- Lone dcache write, addr 0x8000_0040, wdata beats A,B,C,D with pmem_resp held low 2 cycles before beat 2:
  - pmem_wdata sequence A,B,B,B,C,D.
  - pmem_write high for 6 cycles; d_mem_resp 1 pulse.
- i_mem_read and d_mem_read rise in the same cycle after reset:
  - dcache served first, then icache.
  - Repeat the tie: dcache then icache alternate (last_grant toggles).
- dcache busy and icache requests mid-burst:
  - icache waits with no pmem activity for it.
  - icache is granted 2 cycles after d_mem_resp.
- d_mem_read=d_mem_write=1: write burst issued with pmem_write=1, pmem_read=0.
- rst asserted after beat 1 of an icache read:
  - No i_mem_resp; outputs 0 next cycle.
  - A new icache request after rst completes correctly with beat_cnt starting at 0.
